// File: rtl/pss_arb_pkg.sv
// pss_arb_pkg -- shared definitions for the PacketStream arbiters.
//   arb_state_t     : arbiter state (IDLE, PASS, DRAIN)
//   MAX_PORTS       : widest request vector the helper accepts
//   onehot_to_idx() : index of the set bit in a one-hot vector (0 if none)
package pss_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int MAX_PORTS = 16;

   // Callers zero-extend their PORTS-wide vector to MAX_PORTS bits.
   function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/pss_rr_pick.sv
// pss_rr_pick -- combinational rotating-priority picker.
//   req      in  PORTS          request vector
//   last     in  clog2(PORTS)   index of the previous winner
//   pick     out PORTS          one-hot winner, first request after last
//   pick_val out 1              at least one request is present
module pss_rr_pick #(
   parameter int PORTS = 4
) (
   input  logic [PORTS-1:0]         req,
   input  logic [$clog2(PORTS)-1:0] last,
   output logic [PORTS-1:0]         pick,
   output logic                     pick_val
);

   int p;

   // Scan from last+1 around to last itself; the first request seen wins.
   always_comb begin
      pick     = '0;
      pick_val = 1'b0;
      p        = 0;
      for (int k = 1; k <= PORTS; k++) begin
         p = int'(last) + k;
         if (p >= PORTS) p = p - PORTS;
         if (!pick_val && req[p]) begin
            pick[p]  = 1'b1;
            pick_val = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pss_rr_arbiter.sv
// pss_rr_arbiter -- packet-atomic round-robin merge of PORTS PacketStream
// sources onto one output, with a per-packet stall watchdog.
//   clk, rst                 clock; asynchronous active-low reset
//   i_dat/i_val/i_sop/i_eop  per-source stream inputs (i_dat is PORTS*WIDTH)
//   i_rdy                    per-source ready (also high for discarded words)
//   o_dat/o_val/o_sop/o_eop  merged stream output
//   o_rdy                    downstream ready
//   grant                    registered one-hot owner, zero when unowned
//   abort                    registered pulse: output packet ended without EOP
//   lost                     registered per-source pulse: a word was discarded
module pss_rr_arbiter
   import pss_arb_pkg::*;
#(
   parameter int PORTS   = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PORTS*WIDTH-1:0] i_dat,
   input  logic [PORTS-1:0]       i_val,
   input  logic [PORTS-1:0]       i_sop,
   input  logic [PORTS-1:0]       i_eop,
   output logic [PORTS-1:0]       i_rdy,
   output logic [WIDTH-1:0]       o_dat,
   output logic                   o_val,
   output logic                   o_sop,
   output logic                   o_eop,
   input  logic                   o_rdy,
   output logic [PORTS-1:0]       grant,
   output logic                   abort,
   output logic [PORTS-1:0]       lost
);

   localparam int IW = $clog2(PORTS);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t       state_reg, state_next;
   logic [PORTS-1:0] grant_reg, grant_next;
   logic [IW-1:0]    last_reg, last_next;
   logic             first_reg, first_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             abort_reg, abort_next;
   logic [PORTS-1:0] lost_reg;

   // last_reg doubles as the owner index in PASS and the drained port in DRAIN.
   logic own_val, own_sop, own_eop, late_sop, own_acc;
   assign own_val  = i_val[last_reg];
   assign own_sop  = i_sop[last_reg];
   assign own_eop  = i_eop[last_reg];
   // A SOP after the first word means the previous packet lost its EOP.
   assign late_sop = own_val & own_sop & ~first_reg;
   assign own_acc  = (state_reg == PASS) & own_val & ~late_sop & o_rdy;

   logic [PORTS-1:0]     req_sop, pick;
   logic                 pick_val;
   logic [MAX_PORTS-1:0] pick_w;

   assign req_sop = i_val & i_sop;

   pss_rr_pick #(.PORTS(PORTS)) u_pick (
      .req      (req_sop),
      .last     (last_reg),
      .pick     (pick),
      .pick_val (pick_val)
   );

   always_comb begin
      pick_w            = '0;
      pick_w[PORTS-1:0] = pick;
   end

   // Any non-SOP word not belonging to the current owner is headless:
   // accept it, throw it away and report it one cycle later.
   logic [PORTS-1:0] drop;

   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
         logic is_owner;
         assign is_owner  = (state_reg == PASS) && (last_reg == IW'(gi));
         assign drop[gi]  = i_val[gi] & ~i_sop[gi] & ~is_owner;
         assign i_rdy[gi] = drop[gi] | (is_owner & o_rdy & ~late_sop);
      end
   endgenerate

   always_comb begin
      o_dat = '0;
      o_val = 1'b0;
      o_sop = 1'b0;
      o_eop = 1'b0;
      if (state_reg == PASS) begin
         o_dat = i_dat[int'(last_reg)*WIDTH +: WIDTH];
         o_sop = own_sop;
         o_eop = own_eop;
         o_val = own_val & ~late_sop;
      end
   end

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      first_next = first_reg;
      cnt_next   = cnt_reg;
      abort_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_val) begin
               state_next = PASS;
               grant_next = pick;
               last_next  = IW'(onehot_to_idx(pick_w));
               first_next = 1'b1;
               cnt_next   = '0;
            end
         end
         PASS: begin
            if (own_acc) first_next = 1'b0;
            if (own_acc && own_eop) begin
               state_next = IDLE;
               grant_next = '0;
            end else if (late_sop) begin
               state_next = IDLE;
               grant_next = '0;
               abort_next = 1'b1;
            end else if (own_val) begin
               // A presented word (even backpressured) proves the source alive.
               cnt_next = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
               if (TIMEOUT > 0 && cnt_next == CW'(TIMEOUT)) begin
                  state_next = DRAIN;
                  grant_next = '0;
                  abort_next = 1'b1;
               end
            end
         end
         DRAIN: begin
            // Non-SOP words are eaten via drop; an EOP ends the cut, a SOP
            // ends it without being consumed so it can be arbitrated.
            if (own_val && (own_sop || own_eop)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         last_reg  <= IW'(PORTS - 1);
         first_reg <= 1'b0;
         cnt_reg   <= '0;
         abort_reg <= 1'b0;
         lost_reg  <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
         first_reg <= first_next;
         cnt_reg   <= cnt_next;
         abort_reg <= abort_next;
         lost_reg  <= drop;
      end
   end

   assign grant = grant_reg;
   assign abort = abort_reg;
   assign lost  = lost_reg;

endmodule
